// File: rtl/detect_direction_core.sv
// Red-object heading estimator: snoops pixel reads of a frame buffer and reports
// the mean column of red pixels as 0..FOV at each frame end. Optional: DETECT_DIRECTION_HOLD_EN.
module detect_direction_core #(
  parameter int IMAGE_WIDTH   = 320,
  parameter int IMAGE_HEIGHT  = 240,
  parameter int ADDR_BITS     = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
  parameter int NUM_DIVISIONS = 3,
  parameter int FOV           = 25,
  parameter int MAX_SUM       = 12249600,
  parameter int THRESHOLD     = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_BITS-1:0]              rdaddress,
  input  logic [11:0]                       rddata,
  output logic signed [$clog2(FOV)+1-1:0]   direction
);

  localparam int SUM_BITS  = $clog2(MAX_SUM+1);
  localparam int CNT_BITS  = ADDR_BITS + 1;
  localparam int DIR_BITS  = $clog2(FOV) + 1;
  localparam int DIV_BITS  = (SUM_BITS > CNT_BITS) ? SUM_BITS : CNT_BITS;
  localparam int PROD_BITS = DIV_BITS + $clog2(FOV+1);
  localparam int PIXELS    = IMAGE_WIDTH * IMAGE_HEIGHT;

  localparam logic [ADDR_BITS:0]   PIX_LIM = (ADDR_BITS+1)'(PIXELS);
  localparam logic [ADDR_BITS-1:0] WIDTH_A = ADDR_BITS'(IMAGE_WIDTH);
  localparam logic [4:0]           TH5     = 5'(THRESHOLD);

  // NUM_DIVISIONS is carried only so existing instantiations keep elaborating.
  if (NUM_DIVISIONS < 0) begin : g_num_div_unused
  end

  logic [SUM_BITS-1:0]  sum;
  logic [CNT_BITS-1:0]  count;
  logic                 prev_nz;

  logic                 addr_zero;
  logic                 in_range;
  logic                 is_red;
  logic                 accept;
  logic                 frame_end;
  logic [ADDR_BITS-1:0] col;

  logic [DIV_BITS-1:0]  cnt_div;
  logic [DIV_BITS-1:0]  avg;
  logic [PROD_BITS-1:0] prod;
  logic [PROD_BITS-1:0] heading;
  logic [DIR_BITS-1:0]  dir_calc;

  always_comb begin
    addr_zero = (rdaddress == '0);
    in_range  = ({1'b0, rdaddress} < PIX_LIM);
    is_red    = ({1'b0, rddata[11:8]} > ({1'b0, rddata[7:4]} + TH5)) &&
                ({1'b0, rddata[11:8]} > ({1'b0, rddata[3:0]} + TH5));
    accept    = !addr_zero && in_range && is_red;
    frame_end = addr_zero && prev_nz;
    col       = rdaddress % WIDTH_A;
  end

  // Divisor is forced to 1 when empty so the datapath never divides by zero;
  // the result is discarded in that case anyway.
  always_comb begin
    cnt_div  = (count == '0) ? DIV_BITS'(1) : DIV_BITS'(count);
    avg      = DIV_BITS'(sum) / cnt_div;
    prod     = PROD_BITS'(avg) * PROD_BITS'(FOV);
    heading  = prod / PROD_BITS'(IMAGE_WIDTH - 1);
    dir_calc = DIR_BITS'(heading);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      direction <= '1;
      sum       <= '0;
      count     <= '0;
      prev_nz   <= 1'b0;
    end else begin
      prev_nz <= !addr_zero;
      if (addr_zero) begin
        sum   <= '0;
        count <= '0;
        if (frame_end) begin
          if (count != '0) begin
            direction <= dir_calc;
          end else begin
`ifdef DETECT_DIRECTION_HOLD_EN
            direction <= direction;
`else
            direction <= '1;
`endif
          end
        end
      end else if (accept) begin
        count <= count + CNT_BITS'(1);
        sum   <= sum + SUM_BITS'(col);
      end
    end
  end

endmodule

// File: tb/tb_detect_direction_core.sv
// Bench for detect_direction_core: directed vector table followed by random
// pixel streams compared against an arithmetic model of the heading rules.
module tb_detect_direction_core;

  localparam int W         = 320;
  localparam int H         = 240;
  localparam int PIXELS    = W * H;
  localparam int ADDR_BITS = $clog2(PIXELS);
  localparam int FOV       = 25;
  localparam int TH        = 4;
  localparam int DIR_BITS  = $clog2(FOV) + 1;
`ifdef DETECT_DIRECTION_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [ADDR_BITS-1:0]       rdaddress = '0;
  logic [11:0]                rddata = '0;
  logic signed [DIR_BITS-1:0] direction;

  int checks = 0;
  int errors = 0;

  detect_direction_core dut (
    .clk(clk),
    .reset(reset),
    .rdaddress(rdaddress),
    .rddata(rddata),
    .direction(direction)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    int          addr;
    logic [11:0] data;
    int          exp;
    int          exp_hold;
  } vec_t;

  vec_t vt[$];

  // model state: plain integers following the heading rules
  longint m_sum;
  longint m_cnt;
  bit     m_prev_nz;
  int     m_dir;

  function automatic vec_t mk(logic r, int a, logic [11:0] d, int e, int eh);
    vec_t v;
    v.rst = r; v.addr = a; v.data = d; v.exp = e; v.exp_hold = eh;
    return v;
  endfunction

  function automatic bit model_red(logic [11:0] d);
    int r, g, b;
    r = int'(d[11:8]); g = int'(d[7:4]); b = int'(d[3:0]);
    return (r > g + TH) && (r > b + TH);
  endfunction

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_prev_nz = 0; m_dir = -1;
  endtask

  task automatic model_step(logic r, int a, logic [11:0] d);
    if (r) begin
      model_reset();
    end else begin
      if (a == 0) begin
        if (m_prev_nz) begin
          if (m_cnt == 0) begin
            if (!HOLD) m_dir = -1;
          end else begin
            m_dir = int'(((m_sum / m_cnt) * FOV) / (W - 1));
          end
        end
        m_sum = 0;
        m_cnt = 0;
      end else if (a < PIXELS && model_red(d)) begin
        m_cnt = m_cnt + 1;
        m_sum = m_sum + (a % W);
      end
      m_prev_nz = (a != 0);
    end
  endtask

  task automatic apply(logic r, int a, logic [11:0] d);
    @(negedge clk);
    reset     = r;
    rdaddress = ADDR_BITS'(a);
    rddata    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int exp);
    int got;
    got = int'(direction);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: direction got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    // rst, addr, data, expected, expected with hold enabled
    vt.push_back(mk(1,     0, 12'h000, -1, -1));
    vt.push_back(mk(0,     1, 12'h000, -1, -1));
    vt.push_back(mk(0,     0, 12'h000, -1, -1));
    vt.push_back(mk(0,     1, 12'hF00, -1, -1));
    vt.push_back(mk(0,     0, 12'h000,  0,  0));
    vt.push_back(mk(0,   319, 12'hF00,  0,  0));
    vt.push_back(mk(0,     0, 12'h000, 25, 25));
    vt.push_back(mk(0,    12, 12'hF00, 25, 25));
    vt.push_back(mk(0,  1840, 12'hF00, 25, 25));
    vt.push_back(mk(0,     0, 12'h000,  9,  9));
    vt.push_back(mk(0,     5, 12'h840,  9,  9));
    vt.push_back(mk(0,     0, 12'h000, -1,  9));
    vt.push_back(mk(0,    12, 12'hF00, -1,  9));
    vt.push_back(mk(1,  1840, 12'hF00, -1, -1));
    vt.push_back(mk(0,     0, 12'h000, -1, -1));
    vt.push_back(mk(0,  1840, 12'hF00, -1, -1));
    vt.push_back(mk(0,     0, 12'h000, 18, 18));
    vt.push_back(mk(0,     0, 12'h000, 18, 18));
    vt.push_back(mk(0, 76800, 12'hF00, 18, 18));
    vt.push_back(mk(0,     0, 12'h000, -1, 18));
    vt.push_back(mk(0,   100, 12'hF00, -1, 18));
    vt.push_back(mk(0,   100, 12'hF00, -1, 18));
    vt.push_back(mk(0,   300, 12'hF00, -1, 18));
    vt.push_back(mk(0,     0, 12'h000, 13, 13));
    vt.push_back(mk(0,   319, 12'h944, 13, 13));
    vt.push_back(mk(0,     0, 12'h000, 25, 25));
    vt.push_back(mk(0,   319, 12'h948, 25, 25));
    vt.push_back(mk(0,     0, 12'h000, -1, 25));

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].rst, vt[i].addr, vt[i].data);
      check($sformatf("vec%0d", i), HOLD ? vt[i].exp_hold : vt[i].exp);
    end

    // mid-frame reset must not leave the frame-end flag armed
    apply(0, 700, 12'hF00);
    apply(1, 0, 12'h000);
    check("rst_mid", -1);
    apply(0, 0, 12'h000);
    check("rst_no_fe", -1);
    apply(0, 639, 12'hF00);
    check("rst_hold_before_fe", -1);
    apply(0, 0, 12'h000);
    check("rst_fresh_frame", 25);

    // random streams against the model
    apply(1, 0, 12'h000);
    model_reset();
    check("rand_reset", m_dir);
    for (int n = 0; n < 4000; n++) begin
      int sel, a;
      logic r;
      logic [11:0] d;
      sel = int'($urandom_range(0, 15));
      if (sel < 2)       a = 0;
      else if (sel == 2) a = PIXELS + int'($urandom_range(0, (1 << ADDR_BITS) - 1 - PIXELS));
      else               a = int'($urandom_range(1, PIXELS - 1));
      if ($urandom_range(0, 1) == 1)
        d = {4'($urandom_range(6, 15)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        d = 12'($urandom);
      r = ($urandom_range(0, 299) == 0);
      apply(r, a, d);
      model_step(r, a, d);
      check($sformatf("rand%0d", n), m_dir);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_direction_core.md
DETECT_DIRECTION_CORE -- requirements
Module: detect_direction

Interface
REQ-001 Parameter IMAGE_WIDTH, default 320: pixels per image row.
REQ-002 Parameter IMAGE_HEIGHT, default 240: image rows.
REQ-003 Parameter ADDR_BITS, default $clog2(IMAGE_WIDTH*IMAGE_HEIGHT): BRAM address width.
REQ-004 Parameter NUM_DIVISIONS, default 3: accepted for interface compatibility; no functional effect.
REQ-005 Parameter FOV, default 25: camera field of view in degrees, and the maximum direction value.
REQ-006 Parameter MAX_SUM, default 12249600: worst-case column sum; sizes the sum accumulator to $clog2(MAX_SUM+1) bits.
REQ-007 Parameter THRESHOLD, default 4, range 0-8: red-detection margin in 4-bit colour units.
REQ-008 Clock and reset: one clock; reset is synchronous and active-high.
REQ-009 clk  input  1  system clock; all state updates on its rising edge.
REQ-010 reset  input  1  synchronous active-high reset.
REQ-011 rdaddress  input  ADDR_BITS  BRAM address currently being read by the downstream consumer; snooped only.
REQ-012 rddata  input  12  RGB444 pixel at rdaddress: [11:8]=R, [7:4]=G, [3:0]=B.
REQ-013 direction  output  $clog2(FOV)+1, signed, registered  heading 0..FOV from left to right, or -1 (all ones) when no red object is detected.

Function
REQ-014 Each rising edge SHALL sample rdaddress and rddata as one pixel observation.
REQ-015 A pixel SHALL be red when R > G+THRESHOLD and R > B+THRESHOLD, compared unsigned at 5 bits.
REQ-016 The pixel column SHALL be x = rdaddress mod IMAGE_WIDTH.
REQ-017 When rdaddress != 0, rdaddress < IMAGE_WIDTH*IMAGE_HEIGHT and the pixel is red, the block SHALL increment count by 1 and add x to sum.
REQ-018 Pixels at address 0 or at out-of-range addresses SHALL never be accumulated.
REQ-019 Repeated samples of the same address SHALL each be accumulated; the block does not deduplicate.
REQ-020 Frame end is an edge where rdaddress == 0 and the previous sampled rdaddress was nonzero.
REQ-021 At frame end with count == 0, direction SHALL be -1.
REQ-022 At frame end with count > 0:
  - avg = floor(sum/count);
  - direction = floor(avg*FOV/(IMAGE_WIDTH-1));
  - the result lies in 0..FOV.
REQ-023 direction SHALL be updated on the frame-end edge itself, so the new value is visible one clock after rdaddress first reads 0.
REQ-024 On every edge where rdaddress == 0, sum and count SHALL clear to 0.
REQ-025 Consecutive edges with rdaddress == 0 after the first SHALL leave direction unchanged.
REQ-026 direction SHALL hold its value between frame ends.
REQ-027 Division MAY be combinational. Intermediates SHALL be wide enough that no overflow occurs:
  - count: ADDR_BITS+1 bits;
  - product avg*FOV: full width.

Reset
REQ-028 While reset is high at an edge:
  - direction = -1;
  - sum = 0;
  - count = 0;
  - the previous-address-nonzero flag = 0.
REQ-029 Reset SHALL take priority over pixel accumulation and frame-end evaluation in the same cycle.
REQ-030 A reset asserted mid-frame SHALL discard all partial accumulation.

Configuration
REQ-031 Macro DETECT_DIRECTION_HOLD_EN is defined: a frame end with count == 0 SHALL leave direction at its previous value; direction becomes -1 only after reset.
REQ-032 Macro DETECT_DIRECTION_HOLD_EN is undefined (default): REQ-021 applies.

Verification
REQ-033 Reset; addr 1 with rddata 0x000, then addr 0 -> direction == -1.
REQ-034 Addr 1 with 0xF00 for one cycle, then addr 0 -> direction == 0 one clock later.
REQ-035 Addr 319 with 0xF00, then addr 0 -> direction == 25.
REQ-036 Red at addr 12, red at addr 1840 (column 240), then addr 0 -> avg 126 -> direction == 9.
REQ-037 Pixel 0x840 with THRESHOLD=4 (R=8, G=4) -> not red; then addr 0 -> direction == -1.
REQ-038 Assert reset between the two red pixels of REQ-036, then addr 0 -> direction == -1, with no partial sum retained.
